booth_shift_reg: RTL and testbench
==================================

BOOTH_SHIFT_REG -- requirements
Module: booth_shift_reg

Interface
REQ-001 Parameter REG_WIDTH, default 8: storage, inbus and outbus width, minimum 2.
REQ-002 Parameter SHAMT_WIDTH, default 4: shift-amount width; shamt values above REG_WIDTH are legal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 inbus  input  REG_WIDTH  parallel load data.
REQ-006 load  input  1  load inbus into storage (idle only).
REQ-007 dump  input  1  copy storage to outbus (any state).
REQ-008 start  input  1  begin multi-cycle shift of shamt bits (idle only).
REQ-009 shamt  input  SHAMT_WIDTH  number of 1-bit shifts, sampled with start.
REQ-010 mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right; sampled with start.
REQ-011 shiftin  input  1  fill bit for mode 00 (MSB) and mode 10 (LSB), sampled every shift cycle.
REQ-012 outbus  output  REG_WIDTH  registered dump result.
REQ-013 shiftout  output  1  registered last bit shifted out.
REQ-014 busy  output  1  high while in SHIFT state.
REQ-015 done  output  1  one-cycle pulse on shift completion.

Function
REQ-016 The block shall implement two states, IDLE and SHIFT.
REQ-017 In IDLE, command priority shall be load > start; a simultaneous lower-priority command is dropped, not queued.
REQ-018 load in IDLE shall write inbus to storage and clear shiftout to 0 on the same edge.
REQ-019 start in IDLE with shamt=0 shall leave storage unchanged, remain in IDLE and pulse done on the next cycle.
REQ-020 start in IDLE with shamt=N>0 shall latch mode and N, enter SHIFT; busy rises the following cycle.
REQ-021 Each SHIFT cycle shall perform exactly one 1-bit shift and decrement the remaining count; N shifts take N cycles.
REQ-022 Mode 00: storage <= {shiftin, storage[W-1:1]}, shiftout <= storage[0].
REQ-023 Mode 01: storage <= {storage[W-1], storage[W-1:1]}, shiftout <= storage[0].
REQ-024 Mode 10: storage <= {storage[W-2:0], shiftin}, shiftout <= storage[W-1].
REQ-025 Mode 11: storage <= {storage[0], storage[W-1:1]}, shiftout <= storage[0].
REQ-026 On the edge performing the final shift, state shall return to IDLE; done shall be high and busy low in the cycle after that edge.
REQ-027 load and start asserted while busy shall be ignored with no side effect; mode/shamt/shiftin changes shall not affect latched mode or count.
REQ-028 dump shall copy current storage to outbus in any state; during SHIFT it captures the value before that edge's shift.
REQ-029 outbus shall hold its value except on dump; shiftout shall hold except on load or a shift.
REQ-030 A start accepted on the same cycle done is high shall be honoured (back-to-back operations).

Reset
REQ-031 rst_n low shall immediately force storage, outbus, shiftout, busy, done and count to 0 and state to IDLE, independent of clk.
REQ-032 Reset mid-shift shall abort the operation with no done pulse; first command is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 W=8: load 0xB4, start shamt=2 mode=01 -> busy for 2 cycles, done, dump -> outbus 0xED, shiftout 0.
REQ-034 W=8: load 0x81, start shamt=3 mode=10 shiftin=1 -> dump 0x0F, shiftout 0.
REQ-035 W=8: load 0x01, start shamt=9 mode=11 -> 9 busy cycles, dump 0x80, shiftout 1.
REQ-036 load 0x55 with start same cycle -> storage 0x55, no busy, no done; then start shamt=0 -> done pulse, storage 0x55.
REQ-037 load 0xF0, start shamt=4 mode=00 shiftin=0, load 0xAA at cycle 2 -> load ignored, dump 0x0F.
REQ-038 Assert rst_n low during cycle 2 of a 5-shift op -> all outputs 0 asynchronously, no done; new load 0x3C after release -> dump 0x3C.

Source files
------------

// File: rtl/booth_shift_reg_if.sv
// Command/data bundle for booth_shift_reg: the controller drives commands and
// load data, and the shifter returns the dump bus and status.
interface booth_shift_reg_if #(
  parameter int REG_WIDTH   = 8,
  parameter int SHAMT_WIDTH = 4
);
  logic [REG_WIDTH-1:0]   inbus;
  logic                   load;
  logic                   dump;
  logic                   start;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [1:0]             mode;
  logic                   shiftin;
  logic [REG_WIDTH-1:0]   outbus;
  logic                   shiftout;
  logic                   busy;
  logic                   done;

  modport master (
    output inbus, load, dump, start, shamt, mode, shiftin,
    input  outbus, shiftout, busy, done
  );

  modport slave (
    input  inbus, load, dump, start, shamt, mode, shiftin,
    output outbus, shiftout, busy, done
  );
endinterface

// File: rtl/booth_shift_reg.sv
// Multi-cycle shift register: one 1-bit shift per cycle for shamt cycles, in
// one of four modes, with parallel load and a registered dump port.
module booth_shift_reg #(
  parameter int REG_WIDTH   = 8,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_shift_reg_if.slave   bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [REG_WIDTH-1:0]   storage, outbus_q, shifted;
  logic [SHAMT_WIDTH-1:0] count;
  logic [1:0]             mode_q;
  logic                   shiftout_q, done_q;
  logic                   sout, go, last, done_nxt;

  // load outranks start; a start beside a load is simply lost
  always_comb begin
    state_nxt = state;
    go        = (state == IDLE) && bus.start && !bus.load;
    last      = (state == SHIFT) && (count == SHAMT_WIDTH'(1));
    done_nxt  = last || (go && (bus.shamt == '0));
    case (state)
      IDLE:    if (go && (bus.shamt != '0)) state_nxt = SHIFT;
      SHIFT:   if (last)                    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted = storage;
    sout    = storage[0];
    case (mode_q)
      2'b00: shifted = {bus.shiftin, storage[REG_WIDTH-1:1]};
      2'b01: shifted = {storage[REG_WIDTH-1], storage[REG_WIDTH-1:1]};
      2'b10: begin
        shifted = {storage[REG_WIDTH-2:0], bus.shiftin};
        sout    = storage[REG_WIDTH-1];
      end
      default: shifted = {storage[0], storage[REG_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      storage    <= '0;
      outbus_q   <= '0;
      shiftout_q <= 1'b0;
      done_q     <= 1'b0;
      count      <= '0;
      mode_q     <= 2'b00;
    end else begin
      done_q <= done_nxt;
      // dump sees the pre-edge storage, so mid-shift it captures the old value
      if (bus.dump) outbus_q <= storage;
      if (state == IDLE) begin
        if (bus.load) begin
          storage    <= bus.inbus;
          shiftout_q <= 1'b0;
        end else if (go && (bus.shamt != '0)) begin
          count  <= bus.shamt;
          mode_q <= bus.mode;
        end
      end else begin
        storage    <= shifted;
        shiftout_q <= sout;
        count      <= count - 1'b1;
      end
    end
  end

  assign bus.outbus   = outbus_q;
  assign bus.shiftout = shiftout_q;
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_booth_shift_reg.sv
// Bench for booth_shift_reg: directed vectors with literal expectations plus
// randomized traffic compared every cycle against an arithmetic model.
module tb_booth_shift_reg;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk, rst_n;
  int   n_chk = 0, n_fail = 0;
  bit   cmp_en = 0;

  booth_shift_reg_if #(.REG_WIDTH(W), .SHAMT_WIDTH(SW)) bus ();
  booth_shift_reg #(.REG_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st, m_out, m_so, m_done, m_rem, m_mode;

  function automatic void shift1(input int v, input int md, input int fin,
                                 output int nv, output int so);
    case (md)
      0: begin so = v & 1;            nv = (v >> 1) | (fin << (W-1)); end
      1: begin so = v & 1;            nv = (v >> 1) | (v & (1 << (W-1))); end
      2: begin so = (v >> (W-1)) & 1; nv = ((v << 1) | fin) & MASK; end
      default: begin so = v & 1;      nv = (v >> 1) | ((v & 1) << (W-1)); end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nv, so;
    if (!rst_n) begin
      m_st = 0; m_out = 0; m_so = 0; m_done = 0; m_rem = 0; m_mode = 0;
    end else begin
      if (bus.dump) m_out = m_st;
      if (m_rem > 0) begin
        shift1(m_st, m_mode, int'(bus.shiftin), nv, so);
        m_st = nv; m_so = so;
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        m_done = 0;
        if (bus.load) begin
          m_st = bus.inbus; m_so = 0;
        end else if (bus.start) begin
          if (bus.shamt == 0) m_done = 1;
          else begin m_rem = bus.shamt; m_mode = bus.mode; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_outbus",   bus.outbus,   m_out);
      check("cmp_shiftout", bus.shiftout, m_so);
      check("cmp_busy",     bus.busy,     int'(m_rem > 0));
      check("cmp_done",     bus.done,     m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    bus.load = 0; bus.start = 0; bus.dump = 0;
  endtask

  task automatic do_load(input int v);
    bus.inbus = W'(v); bus.load = 1; step(1); bus.load = 0;
  endtask

  task automatic do_start(input int n, input int md, input int fin);
    bus.shamt = SW'(n); bus.mode = 2'(md); bus.shiftin = fin[0];
    bus.start = 1; step(1); bus.start = 0;
  endtask

  task automatic do_dump();
    bus.dump = 1; step(1); bus.dump = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 40) begin step(1); n++; end
    if (n >= 40) check("busy_timeout", n, 0);
  endtask

  initial begin
    int n;
    rst_n = 1; clr();
    bus.inbus = 0; bus.shamt = 0; bus.mode = 0; bus.shiftin = 0;
    #1 rst_n = 0;
    #1;
    check("rst_outbus", bus.outbus, 0);
    check("rst_shiftout", bus.shiftout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    #10 rst_n = 1;
    cmp_en = 1;
    step(1);

    // arithmetic right 2 of 0xB4
    do_load('hB4);
    do_start(2, 1, 0);
    check("t33_busy1", bus.busy, 1);
    step(1);
    check("t33_busy2", bus.busy, 1);
    check("t33_nodone", bus.done, 0);
    step(1);
    check("t33_idle", bus.busy, 0);
    check("t33_done", bus.done, 1);
    do_dump();
    check("t33_outbus", bus.outbus, 'hED);
    check("t33_shiftout", bus.shiftout, 0);
    check("t33_donepulse", bus.done, 0);

    // logical left 3 of 0x81 with fill 1
    do_load('h81);
    do_start(3, 2, 1);
    wait_idle(n);
    check("t34_cycles", n, 3);
    do_dump();
    check("t34_outbus", bus.outbus, 'h0F);
    check("t34_shiftout", bus.shiftout, 0);

    // rotate right 9 (wraps past the width)
    do_load('h01);
    do_start(9, 3, 0);
    wait_idle(n);
    check("t35_cycles", n, 9);
    check("t35_done", bus.done, 1);
    do_dump();
    check("t35_outbus", bus.outbus, 'h80);
    check("t35_shiftout", bus.shiftout, 1);

    // load beats start; then a zero-length start
    bus.inbus = 'h55; bus.load = 1; bus.shamt = 3; bus.start = 1;
    step(1); clr();
    check("t36_nobusy", bus.busy, 0);
    check("t36_nodone", bus.done, 0);
    do_start(0, 0, 0);
    check("t36_done0", bus.done, 1);
    check("t36_busy0", bus.busy, 0);
    step(1);
    check("t36_doneend", bus.done, 0);
    do_dump();
    check("t36_outbus", bus.outbus, 'h55);

    // load and mode change while busy are ignored
    do_load('hF0);
    do_start(4, 0, 0);
    step(1);
    bus.inbus = 'hAA; bus.load = 1; bus.mode = 2; bus.start = 1; bus.shamt = 1;
    step(1); clr();
    wait_idle(n);
    do_dump();
    check("t37_outbus", bus.outbus, 'h0F);

    // async reset in the middle of a 5-shift op
    do_load('hC3);
    do_start(5, 1, 0);
    step(1);
    #2 rst_n = 0;
    #1;
    check("t38_outbus", bus.outbus, 0);
    check("t38_shiftout", bus.shiftout, 0);
    check("t38_busy", bus.busy, 0);
    check("t38_done", bus.done, 0);
    #2 rst_n = 1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      check("t38_nodone", bus.done, 0);
      step(1);
    end
    do_load('h3C);
    do_dump();
    check("t38_reload", bus.outbus, 'h3C);

    // randomized traffic, checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) begin
        clr();
        rst_n = 0; #2 rst_n = 1;
        step(1);
      end else begin
        bus.inbus   = W'($urandom);
        bus.load    = ($urandom_range(7) == 0);
        bus.start   = ($urandom_range(3) == 0);
        bus.dump    = ($urandom_range(2) == 0);
        bus.shamt   = SW'($urandom);
        bus.mode    = 2'($urandom);
        bus.shiftin = 1'($urandom);
        step(1);
      end
    end
    clr();
    step(2);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
